// File: rtl/forward_scoreboard.sv
// Purpose: pipeline scoreboard tracking pending writes in EX..WB, choosing operand forwarding sources and raising the hazard Stall.
// Latency: selects and Stall are combinational from current state and decode inputs; stage state advances on each rising clk edge.
// Backpressure: Stall holds PC/decode on load-use hazards or while a mul/div occupies EX; flush drops only the decode instruction.
//
// Ports:
//   clk, rst_n                  clock and synchronous active-low reset
//   RN1, RN2, RD_ID             decode source operands and destination register
//   WriteReg_ID, WriteR0_ID     decode writes RD_ID / also writes R0 as a side result
//   IsLoad_ID, IsMulDiv_ID      decode instruction class
//   issue_ID, flush             decode holds a valid instruction / kill it this cycle
//   Reg_Forwarding1/2           operand source: 0 = register file, k = stage k
//   Stall                       hold PC and decode this cycle
module forward_scoreboard #(
    parameter int REGISTER_NUMBER_BIT_WIDTH = 4,
    parameter int NUM_FWD_STAGES            = 3,
    parameter int MULDIV_LATENCY            = 4,
    localparam int FWD_SEL_W                = $clog2(NUM_FWD_STAGES + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [REGISTER_NUMBER_BIT_WIDTH-1:0] RN1,
    input  logic [REGISTER_NUMBER_BIT_WIDTH-1:0] RN2,
    input  logic [REGISTER_NUMBER_BIT_WIDTH-1:0] RD_ID,
    input  logic                                 WriteReg_ID,
    input  logic                                 WriteR0_ID,
    input  logic                                 IsLoad_ID,
    input  logic                                 IsMulDiv_ID,
    input  logic                                 issue_ID,
    input  logic                                 flush,
    output logic [FWD_SEL_W-1:0]                 Reg_Forwarding1,
    output logic [FWD_SEL_W-1:0]                 Reg_Forwarding2,
    output logic                                 Stall
);

    localparam int RNW   = REGISTER_NUMBER_BIT_WIDTH;
    localparam int CNT_W = $clog2(MULDIV_LATENCY + 1);

    typedef struct packed {
        logic           valid;
        logic [RNW-1:0] rd;
        logic           wr_reg;
        logic           wr_r0;
        logic           is_load;
    } entry_t;

    // stage_q[1] = EX, stage_q[2] = MEM, ... stage_q[NUM_FWD_STAGES] = last tracked (retires next edge)
    entry_t             stage_q [1:NUM_FWD_STAGES];
    logic [CNT_W-1:0]   cnt_q;

    logic [FWD_SEL_W-1:0] sel1;
    logic [FWD_SEL_W-1:0] sel2;
    logic                 busy;
    logic                 load_use;
    logic                 stall_int;
    logic                 accept;
    entry_t               dec_entry;

    function automatic logic match(input entry_t e, input logic [RNW-1:0] rn);
        return e.valid & ((e.wr_reg & (e.rd == rn)) | (e.wr_r0 & (rn == '0)));
    endfunction

    // Scan from oldest to youngest so the youngest matching stage wins.
    always_comb begin
        sel1 = '0;
        sel2 = '0;
        for (int k = NUM_FWD_STAGES; k >= 1; k--) begin
            if (match(stage_q[k], RN1)) sel1 = FWD_SEL_W'(k);
            if (match(stage_q[k], RN2)) sel2 = FWD_SEL_W'(k);
        end
    end

    // A load in EX has no data yet; only MEM onwards can forward it.
    assign busy      = (cnt_q != '0);
    assign load_use  = stage_q[1].is_load & (match(stage_q[1], RN1) | match(stage_q[1], RN2));
    assign stall_int = busy | load_use;
    assign accept    = issue_ID & ~flush & ~stall_int;

    always_comb begin
        dec_entry         = '0;
        dec_entry.valid   = 1'b1;
        dec_entry.rd      = RD_ID;
        dec_entry.wr_reg  = WriteReg_ID;
        dec_entry.wr_r0   = WriteR0_ID;
        dec_entry.is_load = IsLoad_ID;
    end

    always_comb begin
        Reg_Forwarding1 = '0;
        Reg_Forwarding2 = '0;
        Stall           = 1'b0;
        if (rst_n) begin
            Stall = stall_int;
            if (!stall_int) begin
                Reg_Forwarding1 = sel1;
                Reg_Forwarding2 = sel2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 1; k <= NUM_FWD_STAGES; k++) stage_q[k] <= '0;
            cnt_q <= '0;
        end else if (busy) begin
            // Mul/div still occupies EX: hold it, drain the stages behind it.
            stage_q[2] <= '0;
            for (int k = 3; k <= NUM_FWD_STAGES; k++) stage_q[k] <= stage_q[k-1];
            cnt_q <= cnt_q - CNT_W'(1);
        end else begin
            for (int k = 2; k <= NUM_FWD_STAGES; k++) stage_q[k] <= stage_q[k-1];
            if (accept) begin
                stage_q[1] <= dec_entry;
                if (IsMulDiv_ID) cnt_q <= CNT_W'(MULDIV_LATENCY - 1);
            end else begin
                // Covers load-use stall, flush and empty decode alike.
                stage_q[1] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Purpose: directed self-checking bench for forward_scoreboard with an expected-result queue.
// Latency: inputs driven 1 time unit after posedge, outputs checked at negedge of the same cycle.
// Backpressure: Stall expectations are part of each queued result.
module tb_forward_scoreboard;

    logic       clk;
    logic       rst_n;
    logic [3:0] RN1, RN2, RD_ID;
    logic       WriteReg_ID, WriteR0_ID, IsLoad_ID, IsMulDiv_ID, issue_ID, flush;
    logic [1:0] Reg_Forwarding1, Reg_Forwarding2;
    logic       Stall;

    int n_cmp  = 0;
    int n_fail = 0;

    // {sel1, sel2, stall}
    logic [4:0] exp_q [$];

    forward_scoreboard #(
        .REGISTER_NUMBER_BIT_WIDTH(4),
        .NUM_FWD_STAGES(3),
        .MULDIV_LATENCY(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .RN1(RN1),
        .RN2(RN2),
        .RD_ID(RD_ID),
        .WriteReg_ID(WriteReg_ID),
        .WriteR0_ID(WriteR0_ID),
        .IsLoad_ID(IsLoad_ID),
        .IsMulDiv_ID(IsMulDiv_ID),
        .issue_ID(issue_ID),
        .flush(flush),
        .Reg_Forwarding1(Reg_Forwarding1),
        .Reg_Forwarding2(Reg_Forwarding2),
        .Stall(Stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic idle();
        issue_ID    = 1'b0;
        flush       = 1'b0;
        WriteReg_ID = 1'b0;
        WriteR0_ID  = 1'b0;
        IsLoad_ID   = 1'b0;
        IsMulDiv_ID = 1'b0;
        RD_ID       = 4'd0;
        RN1         = 4'd12;
        RN2         = 4'd12;
    endtask

    task automatic instr(input logic [3:0] rd, input logic wr, input logic wr0,
                         input logic ld, input logic md);
        issue_ID    = 1'b1;
        RD_ID       = rd;
        WriteReg_ID = wr;
        WriteR0_ID  = wr0;
        IsLoad_ID   = ld;
        IsMulDiv_ID = md;
    endtask

    // Queue the expectation, check it against the DUT this cycle, then advance one edge.
    task automatic step(input logic [1:0] e1, input logic [1:0] e2, input logic es,
                        input string tag);
        logic [4:0] e;
        exp_q.push_back({e1, e2, es});
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        assert (Reg_Forwarding1 === e[4:3]) else begin
            n_fail++;
            $error("FAIL %s sel1: observed %0d expected %0d", tag, Reg_Forwarding1, e[4:3]);
        end
        n_cmp++;
        assert (Reg_Forwarding2 === e[2:1]) else begin
            n_fail++;
            $error("FAIL %s sel2: observed %0d expected %0d", tag, Reg_Forwarding2, e[2:1]);
        end
        n_cmp++;
        assert (Stall === e[0]) else begin
            n_fail++;
            $error("FAIL %s stall: observed %0d expected %0d", tag, Stall, e[0]);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #1;
        step(0, 0, 0, "reset_a");
        step(0, 0, 0, "reset_b");

        // Reset clears a pending write in EX
        rst_n = 1'b1;
        instr(4'd3, 1, 0, 0, 0);
        step(0, 0, 0, "rst_issue");
        idle(); rst_n = 1'b0; RN1 = 4'd3;
        step(0, 0, 0, "rst_forced");
        rst_n = 1'b1;
        step(0, 0, 0, "rst_cleared");

        // Flushed instruction never enters EX
        instr(4'd3, 1, 0, 0, 0); flush = 1'b1;
        step(0, 0, 0, "flush_issue");
        idle(); RN1 = 4'd3;
        step(0, 0, 0, "flush_dropped");

        // Distance sweep on R3
        instr(4'd3, 1, 0, 0, 0); RN1 = 4'd1; RN2 = 4'd1;
        step(0, 0, 0, "dist_w");
        instr(4'd8, 1, 0, 0, 0); RN1 = 4'd3;
        step(1, 0, 0, "dist_1");
        instr(4'd9, 1, 0, 0, 0);
        step(2, 0, 0, "dist_2");
        instr(4'd10, 1, 0, 0, 0);
        step(3, 0, 0, "dist_3");
        instr(4'd11, 1, 0, 0, 0);
        step(0, 0, 0, "dist_4");
        idle();
        step(0, 0, 0, "drain_a");
        step(0, 0, 0, "drain_b");
        step(0, 0, 0, "drain_c");

        // Priority: youngest writer of R5 wins
        instr(4'd5, 1, 0, 0, 0);
        step(0, 0, 0, "prio_w1");
        instr(4'd5, 1, 0, 0, 0); RN2 = 4'd5;
        step(0, 1, 0, "prio_w2");
        idle(); RN2 = 4'd5;
        step(0, 1, 0, "prio_s1s2");
        step(0, 2, 0, "prio_s2s3");
        step(0, 3, 0, "prio_s3");
        step(0, 0, 0, "prio_retired");

        // R0 side write
        instr(4'd7, 1, 1, 0, 0);
        step(0, 0, 0, "r0_issue");
        idle(); RN1 = 4'd0; RN2 = 4'd7;
        step(1, 1, 0, "r0_s1");
        step(2, 2, 0, "r0_s2");
        instr(4'd6, 0, 0, 0, 0); RN1 = 4'd0; RN2 = 4'd7;
        step(3, 3, 0, "r0_s3");
        idle(); RN1 = 4'd6; RN2 = 4'd0;
        step(0, 0, 0, "nowrite_nomatch");

        // Load-use
        instr(4'd2, 1, 0, 1, 0);
        step(0, 0, 0, "ld_issue");
        instr(4'd13, 1, 0, 0, 0); RN1 = 4'd2;
        step(0, 0, 1, "ld_use_stall");
        step(2, 0, 0, "ld_use_fwd");

        // Mul/div occupancy, flush during busy leaves the mul in EX
        instr(4'd4, 1, 0, 0, 1); RN1 = 4'd12; RN2 = 4'd12;
        step(0, 0, 0, "mul_issue");
        instr(4'd14, 1, 0, 0, 0); RN1 = 4'd4; RN2 = 4'd13;
        step(0, 0, 1, "mul_busy1");
        flush = 1'b1;
        step(0, 0, 1, "mul_busy2_flush");
        flush = 1'b0;
        step(0, 0, 1, "mul_busy3");
        step(1, 0, 0, "mul_dep");
        idle(); RN1 = 4'd4; RN2 = 4'd14;
        step(2, 1, 0, "mul_after");

        // Reset mid-busy
        instr(4'd4, 1, 0, 0, 1); RN1 = 4'd12; RN2 = 4'd12;
        step(0, 0, 0, "mul2_issue");
        idle(); RN1 = 4'd4;
        step(0, 0, 1, "mul2_busy");
        rst_n = 1'b0;
        step(0, 0, 0, "mul2_rst");
        rst_n = 1'b1;
        step(0, 0, 0, "mul2_after_rst");

        n_cmp++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL queue_empty: observed %0d expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
